bus_cycle_sequencer: RTL
========================

Name: bus_cycle_sequencer

Overview:
Sequences one 8008-style machine cycle on the shared 8-bit multiplexed bus.
- T1: drives the low address byte.
- T2: drives the cycle type plus the high address bits.
- WAIT: stalls while the memory/IO is not ready.
- T3: transfers data (samples the bus on reads, drives it on writes).
- T4/T5: optional internal-execution states.

It sits between the core datapath/control and the tristate bus shared with Memory and I/O.

Parameters:
- AW, 14, address width; the high byte carries AW-8 address bits.
- DW, 8, bus/data width; fixed at 8 for 8008 compatibility.
- Constraint: CTW + (AW-8) == DW, where CTW = 2 is the cycle-type width.

Ports:
- clock, in, 1, system clock; all state changes on posedge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, request a machine cycle; sampled only when accept is high.
- cycle_type, in, 2, cycle code: 00 PCI fetch, 01 PCR read, 10 PCC I/O, 11 PCW write.
- addr, in, AW, cycle address; latched on accept.
- wdata, in, DW, write data; latched on accept.
- need_t45, in, 1, execute T4 and T5 after T3; latched on accept.
- ready, in, 1, memory/IO ready; already synchronized.
- bus, inout tri, DW, shared multiplexed bus.
- rdata, out, DW, data captured in T3 of a non-write cycle.
- rdata_valid, out, 1, one-cycle pulse after rdata updates.
- tstate, out, 3, current state encoding.
- busy, out, 1, tstate != IDLE.
- accept, out, 1, combinational: sequencer can take start this cycle.
- cycle_done, out, 1, high during the final state of a cycle (T3 without T4/T5, or T5).

Behaviour:
- States: IDLE=0, T1=1, T2=2, TWAIT=3, T3=4, T4=5, T5=6.
- accept = (tstate==IDLE) | cycle_done.
- On posedge with accept & start:
  - Latch cycle_type, addr, wdata and need_t45 into internal registers.
  - Next state is T1.
  - Latency from start sampled in IDLE to T1 is one clock.
- With accept & !start: next state is IDLE.
- Transitions:
  - T1 -> T2 unconditionally.
  - T2 -> T3 if ready=1; T2 -> TWAIT if ready=0.
  - TWAIT stays while ready=0 (no timeout); TWAIT -> T3 on the first clock with ready=1.
  - T3 -> T4 if the latched need_t45=1; otherwise T3 is final.
  - T4 -> T5; T5 is final.
- Back-to-back: start asserted during a final state goes straight to T1 with no IDLE gap. Minimum cycle is 3 clocks (T1, T2, T3); 5 clocks with T4/T5.
- Bus drive: combinational decode of tstate and the latched registers, through the tristate driver.
  - T1: addr[7:0].
  - T2: {cycle_type, addr[AW-1:8]}.
  - T3, or TWAIT when cycle_type=PCW: latched wdata.
  - All other states, and T3/TWAIT of non-write cycles: 'z.
- Reads (cycle_type != PCW):
  - At the posedge ending T3, rdata <= bus.
  - rdata_valid is high for exactly the following clock.
  - rdata holds until the next read.
- Writes: rdata and rdata_valid are unchanged.
- Inputs are not re-sampled mid-cycle; changes to addr, wdata or cycle_type after accept have no effect.
- Reset (synchronous, dominates all else):
  - tstate=IDLE, rdata=0, rdata_valid=0, latched registers cleared.
  - bus goes to 'z from the clock after the reset edge; start is ignored that cycle.
  - Reset mid-cycle, including in TWAIT, abandons the cycle with no rdata_valid.
- ready is ignored outside T2 and TWAIT.

Decomposition:
- Package bus_cycle_pkg holds:
  - enum tstate_t (3-bit) and enum cycle_type_t (2-bit) with the codes above.
  - localparams CTW=2 and DW=8.
- FSM and latches live in the module body.
- Tristate drive goes through one BusDriver #(DW) instance (en, data, buff, bus).
- Sub-module bus_byte_mux: combinational selection of the T1/T2/T3 drive byte from tstate and the latched registers.

Test Plan:
1. Fetch: reset, then start with cycle_type=00, addr=14'h2A5C, ready=1, need_t45=0.
   - -> tstate 1,2,4; bus = 8'h5C, then 8'h2A, then z.
   - Memory returns 8'hC3 in T3 -> rdata=8'hC3, rdata_valid high for 1 clock.
2. Wait states: read addr=14'h0010 with ready low for 3 clocks after T2.
   - -> tstate 1,2,3,3,3,4; bus z throughout TWAIT; rdata captured only at end of T3.
3. Write: cycle_type=11, addr=14'h3FFF, wdata=8'hA5, ready=0 for 1 clock.
   - -> bus FF, FF, A5 (TWAIT), A5 (T3); rdata_valid stays 0; tstate returns to 0.
4. Back-to-back with T4/T5: need_t45=1, start held high.
   - -> 1,2,4,5,6 then immediately 1 with no IDLE; cycle_done high only in T5; accept high in T5.
5. Reset mid-cycle: assert reset in TWAIT of a write.
   - -> next clock tstate=0, bus=z, rdata_valid=0.
   - A new start after release begins at T1 with the new addr.
6. Input stability: change addr/cycle_type during T2.
   - -> T2 and T3 behaviour still reflects the values latched at accept.

Source files
------------

// File: rtl/bus_cycle_pkg.sv
// bus_cycle_pkg: shared types and constants for the 8008-style bus cycle sequencer
package bus_cycle_pkg;
  localparam int CTW = 2;
  localparam int DW = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    T1    = 3'd1,
    T2    = 3'd2,
    TWAIT = 3'd3,
    T3    = 3'd4,
    T4    = 3'd5,
    T5    = 3'd6
  } tstate_t;
  typedef enum logic [1:0] {
    PCI = 2'b00,
    PCR = 2'b01,
    PCC = 2'b10,
    PCW = 2'b11
  } cycle_type_t;
endpackage

// File: rtl/BusDriver.sv
// BusDriver: tristate driver onto the shared bus with a read-back buffer
//   en   - drive data onto bus when high, release to z otherwise
//   data - byte to drive
//   buff - current resolved bus value
//   bus  - shared tristate bus
module BusDriver #(
  parameter int DW = 8
) (
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] buff,
  inout  tri   [DW-1:0] bus
);
  assign bus  = en ? data : {DW{1'bz}};
  assign buff = bus;
endmodule

// File: rtl/bus_byte_mux.sv
// bus_byte_mux: selects the byte and drive enable for the current T-state
//   i_st    - current T-state
//   i_ct    - latched cycle type
//   i_addr  - latched address
//   i_wdata - latched write data
//   o_en    - bus drive enable
//   o_byte  - byte to drive
module bus_byte_mux #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic [2:0]    i_st,
  input  logic [1:0]    i_ct,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_en,
  output logic [DW-1:0] o_byte
);
  import bus_cycle_pkg::*;
  logic w_wr;
  assign w_wr = i_ct == PCW;
  always_comb begin
    o_en   = (i_st == T1) | (i_st == T2) | (w_wr & ((i_st == T3) | (i_st == TWAIT)));
    o_byte = (i_st == T1) ? i_addr[7:0] : (i_st == T2) ? {i_ct, i_addr[AW-1:8]} : i_wdata;
  end
endmodule

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: sequences one 8008-style machine cycle (T1,T2,TWAIT,T3,T4,T5) on the multiplexed bus
//   clock/reset  - system clock, synchronous active-high reset
//   start        - request a cycle, taken when accept is high
//   cycle_type, addr, wdata, need_t45 - cycle parameters latched on accept
//   ready        - memory/IO ready, used in T2 and TWAIT
//   bus          - shared tristate bus
//   rdata/rdata_valid - read data and its one-clock valid pulse
//   tstate, busy, accept, cycle_done - sequencer status
module bus_cycle_sequencer #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    cycle_type,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          need_t45,
  input  logic          ready,
  inout  tri   [DW-1:0] bus,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic [2:0]    tstate,
  output logic          busy,
  output logic          accept,
  output logic          cycle_done
);
  import bus_cycle_pkg::*;
  tstate_t     r_state;
  cycle_type_t r_ct;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_t45;
  logic          w_en;
  logic [DW-1:0] w_byte;
  logic [DW-1:0] w_buff;
  logic          w_done;
  assign w_done     = (r_state == T3 && !r_t45) || r_state == T5;
  assign accept     = r_state == IDLE || w_done;
  assign cycle_done = w_done;
  assign busy       = r_state != IDLE;
  assign tstate     = r_state;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ct        <= PCI;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_t45       <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      if (r_state == T3 && r_ct != PCW) begin
        rdata       <= w_buff;
        rdata_valid <= 1'b1;
      end
      if (accept && start) begin
        r_state <= T1;
        r_ct    <= cycle_type_t'(cycle_type);
        r_addr  <= addr;
        r_wdata <= wdata;
        r_t45   <= need_t45;
      end else if (accept) begin
        r_state <= IDLE;
      end else begin
        // T3 only reaches here when T4/T5 were requested
        case (r_state)
          T1:        r_state <= T2;
          T2, TWAIT: r_state <= ready ? T3 : TWAIT;
          T3:        r_state <= T4;
          T4:        r_state <= T5;
          default:   r_state <= IDLE;
        endcase
      end
    end
  end
  bus_byte_mux #(.AW(AW), .DW(DW)) u_mux (
    .i_st   (r_state),
    .i_ct   (r_ct),
    .i_addr (r_addr),
    .i_wdata(r_wdata),
    .o_en   (w_en),
    .o_byte (w_byte)
  );
  BusDriver #(.DW(DW)) u_drv (
    .en  (w_en),
    .data(w_byte),
    .buff(w_buff),
    .bus (bus)
  );
endmodule
